// File: rtl/regfile_bypass.sv
// Multi-read-port register file with a hardwired zero register, same-cycle
// write-to-read bypass and a per-register busy scoreboard for issue tracking.
module regfile_bypass #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 31,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         RegWrite,
  input  logic [ADDR_W-1:0]            WriteAddr,
  input  logic [WIDTH-1:0]             WriteData,
  input  logic [NUM_READ*ADDR_W-1:0]   ReadAddr,
  output logic [NUM_READ*WIDTH-1:0]    ReadData,
  output logic [NUM_READ-1:0]          ReadBusy,
  input  logic                         IssueValid,
  input  logic [ADDR_W-1:0]            IssueAddr,
  output logic                         AnyBusy
);

  localparam bit                ZERO_EN  = (ZERO_REG < DEPTH);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;

  logic write_en;
  logic issue_en;
  logic bypass_active;

  assign write_en      = RegWrite && !(ZERO_EN && (WriteAddr == ZERO_IDX));
  assign issue_en      = IssueValid && !(ZERO_EN && (IssueAddr == ZERO_IDX));
  // Bypass is suppressed while reset is high so every read returns zero.
  assign bypass_active = RegWrite && !Reset;

  // Clear before set: a new producer issuing to the retiring register keeps it busy.
  always_comb begin
    busy_next = busy_reg;
    if (write_en) begin
      busy_next[WriteAddr] = 1'b0;
    end
    if (issue_en) begin
      busy_next[IssueAddr] = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      busy_reg <= '0;
    end else begin
      if (write_en) begin
        regs[WriteAddr] <= WriteData;
      end
      busy_reg <= busy_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_read
      logic [ADDR_W-1:0] rd_addr;
      logic              rd_zero;
      logic              rd_hit;

      assign rd_addr = ReadAddr[gi*ADDR_W +: ADDR_W];
      assign rd_zero = ZERO_EN && (rd_addr == ZERO_IDX);
      assign rd_hit  = bypass_active && (WriteAddr == rd_addr);

      assign ReadData[gi*WIDTH +: WIDTH] = (Reset || rd_zero) ? '0 :
                                           rd_hit            ? WriteData :
                                                               regs[rd_addr];
      assign ReadBusy[gi] = busy_reg[rd_addr] && !rd_hit && !rd_zero;
    end
  endgenerate

  assign AnyBusy = |busy_reg;

endmodule

// File: tb/tb_regfile_bypass.sv
// Self-checking bench for regfile_bypass: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_regfile_bypass;

  logic         Clk;
  logic         Reset;
  logic         RegWrite;
  logic [4:0]   WriteAddr;
  logic [63:0]  WriteData;
  logic [9:0]   ReadAddr;
  logic [127:0] ReadData;
  logic [1:0]   ReadBusy;
  logic         IssueValid;
  logic [4:0]   IssueAddr;
  logic         AnyBusy;

  int checks = 0;
  int errors = 0;
  bit ready  = 0;

  regfile_bypass dut (
    .Clk(Clk), .Reset(Reset), .RegWrite(RegWrite), .WriteAddr(WriteAddr),
    .WriteData(WriteData), .ReadAddr(ReadAddr), .ReadData(ReadData),
    .ReadBusy(ReadBusy), .IssueValid(IssueValid), .IssueAddr(IssueAddr),
    .AnyBusy(AnyBusy)
  );

  initial Clk = 0;
  always #5 Clk = ~Clk;

  // Architectural model: register contents and outstanding-producer flags.
  logic [63:0] m_regs [32];
  logic        m_busy [32];

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] <= '0;
        m_busy[i] <= 1'b0;
      end
    end else begin
      if (RegWrite && WriteAddr != 5'd31) begin
        m_regs[WriteAddr] <= WriteData;
        m_busy[WriteAddr] <= 1'b0;
      end
      if (IssueValid && IssueAddr != 5'd31) m_busy[IssueAddr] <= 1'b1;
    end
  end

  function automatic logic [63:0] exp_data(input logic [4:0] a);
    if (a == 5'd31 || Reset) return '0;
    if (RegWrite && WriteAddr == a) return WriteData;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 5'd31 || Reset) return 1'b0;
    if (RegWrite && WriteAddr == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_any();
    logic r = 1'b0;
    for (int i = 0; i < 32; i++) r |= m_busy[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge Clk) begin
    if (ready) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("model_data%0d", k), ReadData[k*64 +: 64], exp_data(ReadAddr[k*5 +: 5]));
        chk($sformatf("model_busy%0d", k), 64'(ReadBusy[k]), 64'(exp_busy(ReadAddr[k*5 +: 5])));
      end
      chk("model_any", 64'(AnyBusy), 64'(exp_any()));
    end
  end

  task automatic set(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                     input logic iv, input logic [4:0] ia,
                     input logic [4:0] r0, input logic [4:0] r1);
    RegWrite = we; WriteAddr = wa; WriteData = wd;
    IssueValid = iv; IssueAddr = ia; ReadAddr = {r1, r0};
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 0;
    set(0, 0, 0, 0, 0, 0, 0);
    #1 Reset = 1;
    ready = 1;
    for (int a = 0; a < 16; a++) begin
      ReadAddr = {5'(a + 16), 5'(a)};
      #1;
      chk("rst_data0", ReadData[63:0], 64'd0);
      chk("rst_data1", ReadData[127:64], 64'd0);
      chk("rst_busy", 64'(ReadBusy), 64'd0);
    end
    chk("rst_any", 64'(AnyBusy), 64'd0);
    tick();
    Reset = 0;

    // Zero register ignores writes; neighbour keeps its value.
    set(1, 30, 64'h5555, 0, 0, 30, 31); tick();
    set(1, 31, 64'hDEAD, 0, 0, 31, 30); #1;
    chk("zero_wr_same", ReadData[63:0], 64'd0);
    tick();
    set(0, 0, 0, 0, 0, 31, 30); #1;
    chk("zero_rd", ReadData[63:0], 64'd0);
    chk("r30_keep", ReadData[127:64], 64'h5555);
    tick();

    set(1, 5, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0); tick();
    set(0, 0, 0, 0, 0, 5, 6); #1;
    chk("rd5", ReadData[63:0], 64'h0123_4567_89AB_CDEF);
    chk("rd6", ReadData[127:64], 64'd0);
    tick();
    set(1, 5, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 0); tick();
    set(0, 0, 0, 0, 0, 5, 0); #1;
    chk("rd5_neg1", ReadData[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
    tick();

    set(1, 7, 64'd1, 0, 0, 0, 0); tick();
    set(1, 7, 64'd42, 0, 0, 7, 7); #1;
    chk("bypass0", ReadData[63:0], 64'd42);
    chk("bypass1", ReadData[127:64], 64'd42);
    tick();
    set(0, 0, 0, 0, 0, 7, 0); #1;
    chk("bypass_after", ReadData[63:0], 64'd42);
    tick();

    set(0, 0, 0, 1, 3, 3, 3); #1;
    chk("issue_same_cycle", 64'(ReadBusy[0]), 64'd0);
    tick();
    set(0, 0, 0, 0, 0, 3, 0); #1;
    chk("busy3", 64'(ReadBusy[0]), 64'd1);
    chk("any_busy3", 64'(AnyBusy), 64'd1);
    tick();
    set(1, 3, 64'd9, 0, 0, 3, 3); #1;
    chk("busy3_wr", 64'(ReadBusy[0]), 64'd0);
    chk("data3_wr", ReadData[63:0], 64'd9);
    tick();
    set(0, 0, 0, 0, 0, 3, 3); #1;
    chk("any_cleared", 64'(AnyBusy), 64'd0);
    tick();

    set(0, 0, 0, 1, 4, 4, 4); tick();
    set(1, 4, 64'd11, 1, 4, 4, 4); tick();
    set(0, 0, 0, 0, 0, 4, 4); #1;
    chk("collide_busy", 64'(ReadBusy[0]), 64'd1);
    chk("collide_data", ReadData[63:0], 64'd11);
    tick();

    // Reset between edges, held across one edge with a pending write and issue.
    set(1, 2, 64'd77, 1, 2, 0, 0); tick();
    set(1, 2, 64'd123, 1, 2, 2, 2); #1;
    Reset = 1; #1;
    chk("arst_data", ReadData[63:0], 64'd0);
    chk("arst_busy", 64'(ReadBusy), 64'd0);
    chk("arst_any", 64'(AnyBusy), 64'd0);
    tick();
    Reset = 0;
    set(0, 0, 0, 0, 0, 2, 4); #1;
    chk("arst_no_wr", ReadData[63:0], 64'd0);
    chk("arst_no_issue", 64'(ReadBusy[0]), 64'd0);
    chk("arst_r4", ReadData[127:64], 64'd0);
    tick();

    for (int n = 0; n < 3000; n++) begin
      logic [4:0] wa;
      logic [4:0] r0;
      logic [4:0] r1;
      wa = 5'($urandom_range(0, 31));
      r0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? r0 : 5'($urandom_range(0, 31));
      set(1'($urandom_range(0, 1)), wa, {$urandom, $urandom},
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), r0, r1);
      if ($urandom_range(0, 199) == 0) begin
        #1 Reset = 1;
        #1 Reset = 0;
      end
      tick();
    end

    ready = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
